// File: rtl/derr_row_sched_pkg.sv
// Shared definitions for the diffusion-error row scheduler and the error split.
package derr_row_sched_pkg;

    localparam int DERR_W = 48;   // 6 signed bytes from the quantiser
    localparam int ERR_W  = 32;   // 4 signed bytes presented / stored
    localparam int CH_W   = 24;   // bits per chroma channel in derr
    localparam int OUT_CH = 16;   // bits per chroma channel in left/top
    localparam int B_A    = 0;    // byte lane of a (kept as l0)
    localparam int B_B    = 1;    // byte lane of b (kept as t0)
    localparam int B_E    = 2;    // byte lane of e (split into l1/t1)

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_RWAIT = 3'd2,
        S_PRES  = 3'd3,
        S_WDERR = 3'd4,
        S_WR    = 3'd5
    } state_e;

endpackage

// File: rtl/derr_row_sched_split.sv
// Combinational split of a 48-bit error vector into left and top halves.
// Per channel: l0=a, l1=(3*e)>>>2, t0=b, t1=e-l1 (all signed bytes).
module derr_split
    import derr_row_sched_pkg::*;
(
    input  logic [DERR_W-1:0] derr_i,
    output logic [ERR_W-1:0]  left_o,
    output logic [ERR_W-1:0]  top_o
);

    for (genvar c = 0; c < 2; c++) begin : gen_ch
        logic [7:0] a, b, e, l1;
        logic [9:0] e10, p;

        assign a   = derr_i[c*CH_W + B_A*8 +: 8];
        assign b   = derr_i[c*CH_W + B_B*8 +: 8];
        assign e   = derr_i[c*CH_W + B_E*8 +: 8];
        // 3*e fits in 10 signed bits; >>>2 then truncate to 8 is bits [9:2]
        assign e10 = {{2{e[7]}}, e};
        assign p   = e10 + {e10[8:0], 1'b0};
        assign l1  = p[9:2];

        assign left_o[c*OUT_CH +: 8]     = a;
        assign left_o[c*OUT_CH + 8 +: 8] = l1;
        assign top_o[c*OUT_CH +: 8]      = b;
        assign top_o[c*OUT_CH + 8 +: 8]  = e - l1;
    end

endmodule

// File: rtl/derr_row_sched.sv
// Per-MB chroma diffusion-error scheduler: reads top errors for column x,
// presents left/top to the quantiser, then writes the new top half back.
module derr_row_sched
    import derr_row_sched_pkg::*;
#(
    parameter int AW      = 10,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              mb_start_i,
    input  logic [AW-1:0]     mb_x_i,
    input  logic [9:0]        mb_y_i,
    input  logic              derr_valid_i,
    input  logic [DERR_W-1:0] derr_i,
    output logic              err_vld_o,
    output logic [ERR_W-1:0]  left_err_o,
    output logic [ERR_W-1:0]  top_err_o,
    output logic              busy_o,
    output logic              mb_done_o,
    output logic              ram_en_o,
    output logic              ram_wea_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic [ERR_W-1:0]  ram_wdata_o,
    input  logic [ERR_W-1:0]  ram_rdata_i
);

    localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

    state_e             state_q, state_d;
    logic [1:0]         cnt_q;
    logic [AW-1:0]      x_q;
    logic [9:0]         y_q;
    logic [ERR_W-1:0]   left_q, lh_q, th_q;
    logic [ERR_W-1:0]   left_err_q, top_err_q;
    logic               err_vld_q, mb_done_q;
    logic [ERR_W-1:0]   split_l, split_t;

    derr_split u_split (
        .derr_i (derr_i),
        .left_o (split_l),
        .top_o  (split_t)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: fixed read latency, then wait for the quantiser's error vector
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mb_start_i)       state_d = S_RD;
            S_RD:                          state_d = S_RWAIT;
            S_RWAIT: if (cnt_q == LAT_LAST) state_d = S_PRES;
            S_PRES:                        state_d = S_WDERR;
            S_WDERR: if (derr_valid_i)     state_d = S_WR;
            S_WR:                          state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    // Line-buffer port and busy decode; the port is only driven in RD and WR
    always_comb begin
        busy_o      = (state_q != S_IDLE);
        ram_en_o    = (state_q == S_RD) || (state_q == S_WR);
        ram_wea_o   = (state_q == S_WR);
        ram_addr_o  = ram_en_o ? x_q : '0;
        ram_wdata_o = (state_q == S_WR) ? th_q : '0;
    end

    // Datapath: MB coordinates, latency counter, presented errors, split results
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            left_q     <= '0;
            lh_q       <= '0;
            th_q       <= '0;
            left_err_q <= '0;
            top_err_q  <= '0;
            err_vld_q  <= 1'b0;
            mb_done_q  <= 1'b0;
        end else begin
            cnt_q     <= (state_q == S_RWAIT) ? cnt_q + 2'd1 : 2'd0;
            err_vld_q <= (state_q == S_RWAIT) && (state_d == S_PRES);
            mb_done_q <= (state_q == S_WR);
            if (state_q == S_IDLE && mb_start_i) begin
                x_q <= mb_x_i;
                y_q <= mb_y_i;
            end
            // Read data is valid in the last RWAIT cycle; capture it for PRES
            if (state_q == S_RWAIT && state_d == S_PRES) begin
                left_err_q <= (x_q == '0) ? '0 : left_q;
                top_err_q  <= (y_q == '0) ? '0 : ram_rdata_i;
            end
            if (state_q == S_WDERR && derr_valid_i) begin
                lh_q <= split_l;
                th_q <= split_t;
            end
            if (state_q == S_WR) left_q <= lh_q;
        end
    end

    assign err_vld_o  = err_vld_q;
    assign left_err_o = left_err_q;
    assign top_err_o  = top_err_q;
    assign mb_done_o  = mb_done_q;

endmodule
